rename_map: RTL and testbench

RENAME_MAP -- requirements
Module: rename_map

---
 rtl/rename_map_if.sv | 52 +++++
 rtl/rename_map.sv | 190 +++++++++++++++++++
 tb/tb_rename_map.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rename_map_if.sv
// Rename map bundle: dispatch lanes, source lookups, CDB/commit broadcasts and checkpoint control.
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif

interface rename_map_if #(
    parameter int DISP_W   = 2,
    parameter int TAG_W    = `ROB_TAG_LEN,
    parameter int NUM_CKPT = 4,
    parameter int CK_W     = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1
);
    logic [DISP_W-1:0]            disp_valid;
    logic [DISP_W-1:0][4:0]       disp_rs1;
    logic [DISP_W-1:0][4:0]       disp_rs2;
    logic [DISP_W-1:0][4:0]       disp_rd;
    logic [DISP_W-1:0][TAG_W-1:0] disp_tag;
    logic [DISP_W-1:0]            rs1_busy;
    logic [DISP_W-1:0][TAG_W-1:0] rs1_tag;
    logic [DISP_W-1:0]            rs1_ready;
    logic [DISP_W-1:0]            rs2_busy;
    logic [DISP_W-1:0][TAG_W-1:0] rs2_tag;
    logic [DISP_W-1:0]            rs2_ready;
    logic                         cdb_valid;
    logic [4:0]                   cdb_rd;
    logic [TAG_W-1:0]             cdb_tag;
    logic                         commit_valid;
    logic [4:0]                   commit_rd;
    logic [TAG_W-1:0]             commit_tag;
    logic                         ckpt_req;
    logic [CK_W-1:0]              ckpt_id;
    logic                         ckpt_full;
    logic                         ckpt_free;
    logic [CK_W-1:0]              ckpt_free_id;
    logic                         recover;
    logic [CK_W-1:0]              recover_id;

    modport master (
        output disp_valid, disp_rs1, disp_rs2, disp_rd, disp_tag,
               cdb_valid, cdb_rd, cdb_tag, commit_valid, commit_rd, commit_tag,
               ckpt_req, ckpt_free, ckpt_free_id, recover, recover_id,
        input  rs1_busy, rs1_tag, rs1_ready, rs2_busy, rs2_tag, rs2_ready,
               ckpt_id, ckpt_full
    );

    modport slave (
        input  disp_valid, disp_rs1, disp_rs2, disp_rd, disp_tag,
               cdb_valid, cdb_rd, cdb_tag, commit_valid, commit_rd, commit_tag,
               ckpt_req, ckpt_free, ckpt_free_id, recover, recover_id,
        output rs1_busy, rs1_tag, rs1_ready, rs2_busy, rs2_tag, rs2_ready,
               ckpt_id, ckpt_full
    );
endinterface

// File: rtl/rename_map.sv
// Register rename map with same-cycle CDB/dispatch forwarding and optional branch checkpoints.
// Define RENAME_MAP_CKPT_EN for snapshot slots; without it recover flushes the whole map.
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif

module rename_map #(
    parameter int NUM_REGS = 32,
    parameter int TAG_W    = `ROB_TAG_LEN,
    parameter int DISP_W   = 2,
    parameter int NUM_CKPT = 4
) (
    input  logic        clock,
    input  logic        reset,
    rename_map_if.slave bus
);
    localparam int CK_W = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1;

    typedef struct packed {
        logic             busy;
        logic [TAG_W-1:0] tag;
        logic             ready;
    } entry_t;

    logic                         cdb_v_s;
    logic [4:0]                   cdb_rd_s;
    logic [TAG_W-1:0]             cdb_tag_s;
    logic                         cmt_v_s;
    logic [4:0]                   cmt_rd_s;
    logic [TAG_W-1:0]             cmt_tag_s;
    logic                         recover_s;
    logic [DISP_W-1:0]            disp_v_s;
    logic [DISP_W-1:0][4:0]       disp_rd_s;
    logic [DISP_W-1:0][TAG_W-1:0] disp_tag_s;

    assign cdb_v_s    = bus.cdb_valid;
    assign cdb_rd_s   = bus.cdb_rd;
    assign cdb_tag_s  = bus.cdb_tag;
    assign cmt_v_s    = bus.commit_valid;
    assign cmt_rd_s   = bus.commit_rd;
    assign cmt_tag_s  = bus.commit_tag;
    assign recover_s  = bus.recover;
    assign disp_v_s   = bus.disp_valid;
    assign disp_rd_s  = bus.disp_rd;
    assign disp_tag_s = bus.disp_tag;

    entry_t map_r      [NUM_REGS];
    entry_t map_next_s [NUM_REGS];
    entry_t base_s     [NUM_REGS];
    entry_t rs1_e_s    [DISP_W];
    entry_t rs2_e_s    [DISP_W];

    // A commit only retires the mapping it names; a younger rename keeps the entry alive.
    function automatic entry_t apply_bcast(input entry_t e, input logic [4:0] idx);
        entry_t n;
        n = e;
        if (cmt_v_s && (cmt_rd_s == idx) && e.busy && (e.tag == cmt_tag_s)) begin
            n = '0;
        end else if (cdb_v_s && (cdb_rd_s == idx) && (idx != 5'd0) && e.busy && (e.tag == cdb_tag_s)) begin
            n.ready = 1'b1;
        end else begin
            n = e;
        end
        return n;
    endfunction

    function automatic entry_t read_src(input logic [4:0] src, input int lane);
        entry_t e;
        e = map_r[src];
        if (e.busy && cdb_v_s && (e.tag == cdb_tag_s)) e.ready = 1'b1;
        else e.ready = e.ready;
        for (int i = 0; i < DISP_W; i++) begin
            if ((i < lane) && !recover_s && disp_v_s[i] && (disp_rd_s[i] == src)) e = {1'b1, disp_tag_s[i], 1'b0};
            else e = e;
        end
        if (src == 5'd0) e = '0;
        else e = e;
        return e;
    endfunction

    // Source lookups with CDB and intra-group forwarding.
    always_comb begin
        for (int j = 0; j < DISP_W; j++) begin
            rs1_e_s[j]       = read_src(bus.disp_rs1[j], j);
            rs2_e_s[j]       = read_src(bus.disp_rs2[j], j);
            bus.rs1_busy[j]  = rs1_e_s[j].busy;
            bus.rs1_tag[j]   = rs1_e_s[j].tag;
            bus.rs1_ready[j] = rs1_e_s[j].ready;
            bus.rs2_busy[j]  = rs2_e_s[j].busy;
            bus.rs2_tag[j]   = rs2_e_s[j].tag;
            bus.rs2_ready[j] = rs2_e_s[j].ready;
        end
    end

    // Next map: live or restored base, then commit/CDB, then dispatch (youngest lane last).
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            map_next_s[r] = apply_bcast(base_s[r], 5'(r));
            for (int i = 0; i < DISP_W; i++) begin
                if (!recover_s && disp_v_s[i] && (disp_rd_s[i] == 5'(r)) && (r != 0)) map_next_s[r] = {1'b1, disp_tag_s[i], 1'b0};
                else map_next_s[r] = map_next_s[r];
            end
        end
    end

    // Live map register.
    always_ff @(posedge clock) begin
        for (int r = 0; r < NUM_REGS; r++) begin
            if (!reset) map_r[r] <= '0;
            else map_r[r] <= map_next_s[r];
        end
    end

`ifdef RENAME_MAP_CKPT_EN
    entry_t              ck_map_r [NUM_CKPT][NUM_REGS];
    logic [NUM_CKPT-1:0] ck_younger_r [NUM_CKPT];
    logic [NUM_CKPT-1:0] ck_valid_r;
    logic [NUM_CKPT-1:0] ck_valid_next_s;
    logic [CK_W-1:0]     free_idx_s;
    logic                full_s;
    logic                alloc_s;

    // Base for the next map: the selected snapshot on recover, else the live map.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            if (recover_s) base_s[r] = ck_map_r[bus.recover_id][r];
            else base_s[r] = map_r[r];
        end
    end

    // Slot bookkeeping: lowest free slot, allocation, release and recovery squash.
    always_comb begin
        free_idx_s = '0;
        for (int k = NUM_CKPT - 1; k >= 0; k--) begin
            if (!ck_valid_r[k]) free_idx_s = CK_W'(k);
            else free_idx_s = free_idx_s;
        end
        full_s          = &ck_valid_r;
        alloc_s         = bus.ckpt_req && !full_s && !recover_s;
        ck_valid_next_s = ck_valid_r;
        if (bus.ckpt_free) ck_valid_next_s[bus.ckpt_free_id] = 1'b0;
        else ck_valid_next_s = ck_valid_next_s;
        // ck_younger_r[k] holds every slot allocated after slot k.
        if (recover_s) ck_valid_next_s = ck_valid_next_s & ~(ck_younger_r[bus.recover_id] | (NUM_CKPT'(1'b1) << bus.recover_id));
        else ck_valid_next_s = ck_valid_next_s;
        if (alloc_s) ck_valid_next_s[free_idx_s] = 1'b1;
        else ck_valid_next_s = ck_valid_next_s;
    end

    // Snapshot storage: capture on allocation, otherwise follow commits and CDB like the live map.
    always_ff @(posedge clock) begin
        if (!reset) begin
            ck_valid_r <= '0;
            for (int k = 0; k < NUM_CKPT; k++) begin
                ck_younger_r[k] <= '0;
                for (int r = 0; r < NUM_REGS; r++) ck_map_r[k][r] <= '0;
            end
        end else begin
            ck_valid_r <= ck_valid_next_s;
            for (int k = 0; k < NUM_CKPT; k++) begin
                if (alloc_s && (free_idx_s == CK_W'(k))) begin
                    ck_younger_r[k] <= '0;
                    for (int r = 0; r < NUM_REGS; r++) ck_map_r[k][r] <= map_next_s[r];
                end else begin
                    if (alloc_s && ck_valid_r[k]) ck_younger_r[k][free_idx_s] <= 1'b1;
                    else ck_younger_r[k] <= ck_younger_r[k];
                    for (int r = 0; r < NUM_REGS; r++) ck_map_r[k][r] <= apply_bcast(ck_map_r[k][r], 5'(r));
                end
            end
        end
    end

    assign bus.ckpt_id   = free_idx_s;
    assign bus.ckpt_full = full_s;
`else
    logic unused_ckpt_s;

    // Without snapshots a recover restores an empty map.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            if (recover_s) base_s[r] = '0;
            else base_s[r] = map_r[r];
        end
    end

    assign unused_ckpt_s = ^{bus.ckpt_req, bus.ckpt_free, bus.ckpt_free_id, bus.recover_id};
    assign bus.ckpt_id   = '0;
    assign bus.ckpt_full = 1'b1;
`endif
endmodule

// File: tb/tb_rename_map.sv
// Self-checking bench for rename_map: directed scenarios then random traffic against a table model.
module tb_rename_map;
    localparam int NR = 32;
    localparam int TW = 6;
    localparam int DW = 2;
    localparam int NC = 4;
    localparam int CW = 2;
`ifdef RENAME_MAP_CKPT_EN
    localparam bit CKPT_EN = 1'b1;
`else
    localparam bit CKPT_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    rename_map_if #(.DISP_W(DW), .TAG_W(TW), .NUM_CKPT(NC)) bus ();
    rename_map #(.NUM_REGS(NR), .TAG_W(TW), .DISP_W(DW), .NUM_CKPT(NC)) dut (
        .clock(clock), .reset(reset), .bus(bus)
    );

    // model entry = {busy, tag, ready}
    logic [TW+1:0] m_map [NR];
    logic [TW+1:0] s_map [NC][NR];
    int order[$];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic idle();
        bus.disp_valid = '0; bus.disp_rs1 = '0; bus.disp_rs2 = '0; bus.disp_rd = '0; bus.disp_tag = '0;
        bus.cdb_valid = 1'b0; bus.cdb_rd = 5'd0; bus.cdb_tag = '0;
        bus.commit_valid = 1'b0; bus.commit_rd = 5'd0; bus.commit_tag = '0;
        bus.ckpt_req = 1'b0; bus.ckpt_free = 1'b0; bus.ckpt_free_id = '0;
        bus.recover = 1'b0; bus.recover_id = '0;
    endtask

    function automatic bit slot_valid(input int k);
        foreach (order[p]) if (order[p] == k) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int exp_id();
        if (!CKPT_EN) return 0;
        for (int k = 0; k < NC; k++) if (!slot_valid(k)) return k;
        return 0;
    endfunction

    function automatic bit exp_full();
        if (!CKPT_EN) return 1'b1;
        return order.size() == NC;
    endfunction

    function automatic logic [TW+1:0] bcast(input logic [TW+1:0] e, input int r);
        logic [TW+1:0] n;
        n = e;
        if (r != 0 && bus.cdb_valid && bus.cdb_rd == 5'(r) && e[TW+1] && e[TW:1] == bus.cdb_tag) n[0] = 1'b1;
        if (r != 0 && bus.commit_valid && bus.commit_rd == 5'(r) && e[TW+1] && e[TW:1] == bus.commit_tag) n = '0;
        return n;
    endfunction

    function automatic logic [TW+1:0] model_lookup(input logic [4:0] src, input int lane);
        logic [TW+1:0] e;
        if (src == 5'd0) return '0;
        if (!bus.recover)
            for (int i = lane - 1; i >= 0; i--)
                if (bus.disp_valid[i] && bus.disp_rd[i] == src) return {1'b1, bus.disp_tag[i], 1'b0};
        e = m_map[src];
        if (e[TW+1] && bus.cdb_valid && e[TW:1] == bus.cdb_tag) e[0] = 1'b1;
        return e;
    endfunction

    task automatic model_update();
        logic [TW+1:0] nm [NR];
        int a, pos;
        bit alloc;
        if (!reset) begin
            for (int r = 0; r < NR; r++) m_map[r] = '0;
            for (int k = 0; k < NC; k++) for (int r = 0; r < NR; r++) s_map[k][r] = '0;
            order.delete();
        end else begin
            a = exp_id();
            alloc = CKPT_EN && bus.ckpt_req && !bus.recover && (order.size() < NC);
            for (int r = 0; r < NR; r++) begin
                if (bus.recover) nm[r] = CKPT_EN ? s_map[bus.recover_id][r] : '0;
                else nm[r] = m_map[r];
                nm[r] = bcast(nm[r], r);
            end
            if (!bus.recover)
                for (int i = 0; i < DW; i++)
                    if (bus.disp_valid[i] && bus.disp_rd[i] != 5'd0) nm[bus.disp_rd[i]] = {1'b1, bus.disp_tag[i], 1'b0};
            if (CKPT_EN) begin
                for (int k = 0; k < NC; k++) for (int r = 0; r < NR; r++) s_map[k][r] = bcast(s_map[k][r], r);
                if (bus.ckpt_free)
                    for (int p = order.size() - 1; p >= 0; p--) if (order[p] == int'(bus.ckpt_free_id)) order.delete(p);
                if (bus.recover) begin
                    pos = -1;
                    foreach (order[p]) if (order[p] == int'(bus.recover_id)) pos = p;
                    if (pos >= 0) while (order.size() > pos) void'(order.pop_back());
                end
                if (alloc) begin
                    for (int r = 0; r < NR; r++) s_map[a][r] = nm[r];
                    order.push_back(a);
                end
            end
            for (int r = 0; r < NR; r++) m_map[r] = nm[r];
        end
    endtask

    task automatic settle(input string ph);
        logic [TW+1:0] e;
        #1;
        for (int j = 0; j < DW; j++) begin
            e = model_lookup(bus.disp_rs1[j], j);
            chk($sformatf("%s rs1_busy[%0d]", ph, j), 32'(bus.rs1_busy[j]), 32'(e[TW+1]));
            chk($sformatf("%s rs1_ready[%0d]", ph, j), 32'(bus.rs1_ready[j]), 32'(e[0]));
            if (e[TW+1]) chk($sformatf("%s rs1_tag[%0d]", ph, j), 32'(bus.rs1_tag[j]), 32'(e[TW:1]));
            e = model_lookup(bus.disp_rs2[j], j);
            chk($sformatf("%s rs2_busy[%0d]", ph, j), 32'(bus.rs2_busy[j]), 32'(e[TW+1]));
            chk($sformatf("%s rs2_ready[%0d]", ph, j), 32'(bus.rs2_ready[j]), 32'(e[0]));
            if (e[TW+1]) chk($sformatf("%s rs2_tag[%0d]", ph, j), 32'(bus.rs2_tag[j]), 32'(e[TW:1]));
        end
        chk({ph, " ckpt_full"}, 32'(bus.ckpt_full), 32'(exp_full()));
        chk({ph, " ckpt_id"}, 32'(bus.ckpt_id), 32'(exp_id()));
    endtask

    task automatic advance();
        model_update();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic disp(input int lane, input int rd, input int tag);
        bus.disp_valid[lane] = 1'b1;
        bus.disp_rd[lane] = 5'(rd);
        bus.disp_tag[lane] = TW'(tag);
    endtask

    task automatic do_reset();
        idle(); reset = 1'b0; settle("rst_pulse"); advance(); reset = 1'b1;
    endtask

    initial begin
        int r;
        idle();
        reset = 1'b0;
        @(negedge clock);
        advance();
        reset = 1'b1;
        bus.disp_rs1[0] = 5'd3; bus.disp_rs2[1] = 5'd31;
        settle("reset_state");
        chk("reset ckpt_full", 32'(bus.ckpt_full), CKPT_EN ? 32'd0 : 32'd1);
        advance();

        // intra-group forwarding: lane0 writes r5, lane1 reads it
        idle(); disp(0, 5, 3); bus.disp_valid[1] = 1'b1; bus.disp_rs1[1] = 5'd5;
        settle("grp_fwd");
        chk("grp rs1_busy", 32'(bus.rs1_busy[1]), 32'd1);
        chk("grp rs1_tag", 32'(bus.rs1_tag[1]), 32'd3);
        chk("grp rs1_ready", 32'(bus.rs1_ready[1]), 32'd0);
        advance();

        // CDB bypass for r5 (tag 3), then the entry stays ready
        idle(); bus.cdb_valid = 1'b1; bus.cdb_rd = 5'd5; bus.cdb_tag = TW'(3); bus.disp_rs2[0] = 5'd5;
        settle("cdb_bypass");
        chk("cdb rs2_ready", 32'(bus.rs2_ready[0]), 32'd1);
        advance();
        idle(); bus.disp_rs2[0] = 5'd5;
        settle("cdb_held");
        chk("cdb held ready", 32'(bus.rs2_ready[0]), 32'd1);
        chk("cdb held tag", 32'(bus.rs2_tag[0]), 32'd3);
        advance();

        // stale commit keeps the younger rename
        idle(); disp(0, 7, 2); settle("r7_t2"); advance();
        idle(); disp(1, 7, 6); settle("r7_t6"); advance();
        idle(); bus.commit_valid = 1'b1; bus.commit_rd = 5'd7; bus.commit_tag = TW'(2); settle("stale_commit"); advance();
        idle(); bus.disp_rs1[0] = 5'd7;
        settle("after_stale");
        chk("stale busy", 32'(bus.rs1_busy[0]), 32'd1);
        chk("stale tag", 32'(bus.rs1_tag[0]), 32'd6);
        bus.commit_valid = 1'b1; bus.commit_rd = 5'd7; bus.commit_tag = TW'(6);
        advance();
        idle(); bus.disp_rs1[0] = 5'd7;
        settle("after_commit");
        chk("commit busy", 32'(bus.rs1_busy[0]), 32'd0);
        advance();

`ifndef RENAME_MAP_CKPT_EN
        // recover without snapshots flushes everything, dispatch ignored
        idle(); disp(0, 9, 4); disp(1, 11, 5); settle("pre_flush"); advance();
        idle(); bus.recover = 1'b1; disp(0, 6, 7); settle("flush"); advance();
        idle(); bus.disp_rs1[0] = 5'd5; bus.disp_rs2[0] = 5'd6; bus.disp_rs1[1] = 5'd9; bus.disp_rs2[1] = 5'd11;
        settle("post_flush");
        chk("flush r5", 32'(bus.rs1_busy[0]), 32'd0);
        chk("flush r6", 32'(bus.rs2_busy[0]), 32'd0);
        chk("flush r9", 32'(bus.rs1_busy[1]), 32'd0);
        chk("flush r11", 32'(bus.rs2_busy[1]), 32'd0);
        advance();
`endif

        // reset wins over a recover
        idle(); disp(0, 12, 8); bus.ckpt_req = 1'b1; settle("pre_rst_rec"); advance();
        idle(); bus.recover = 1'b1; disp(0, 13, 9); reset = 1'b0; settle("rst_rec"); advance();
        reset = 1'b1; idle(); bus.disp_rs1[0] = 5'd12; bus.disp_rs2[0] = 5'd13;
        settle("post_rst_rec");
        chk("rst_rec r12", 32'(bus.rs1_busy[0]), 32'd0);
        chk("rst_rec r13", 32'(bus.rs2_busy[0]), 32'd0);
        chk("rst_rec full", 32'(bus.ckpt_full), CKPT_EN ? 32'd0 : 32'd1);
        advance();

`ifdef RENAME_MAP_CKPT_EN
        do_reset();
        idle(); disp(0, 4, 1); bus.ckpt_req = 1'b1; settle("ck0");
        chk("ck0 id", 32'(bus.ckpt_id), 32'd0); advance();
        idle(); disp(0, 4, 9); bus.ckpt_req = 1'b1; settle("ck1");
        chk("ck1 id", 32'(bus.ckpt_id), 32'd1); advance();
        idle(); bus.cdb_valid = 1'b1; bus.cdb_rd = 5'd4; bus.cdb_tag = TW'(1); settle("ck_cdb"); advance();
        idle(); bus.recover = 1'b1; bus.recover_id = CW'(0); settle("ck_rec"); advance();
        idle(); bus.disp_rs1[0] = 5'd4;
        settle("ck_restored");
        chk("restored busy", 32'(bus.rs1_busy[0]), 32'd1);
        chk("restored tag", 32'(bus.rs1_tag[0]), 32'd1);
        chk("restored ready", 32'(bus.rs1_ready[0]), 32'd1);
        chk("restored id", 32'(bus.ckpt_id), 32'd0);
        bus.ckpt_req = 1'b1; advance();
        idle(); settle("younger_gone");
        chk("younger slot free", 32'(bus.ckpt_id), 32'd1); advance();

        do_reset();
        for (int k = 0; k < NC; k++) begin
            idle(); bus.ckpt_req = 1'b1; settle("fill");
            chk("fill id", 32'(bus.ckpt_id), 32'(k)); advance();
        end
        idle(); bus.ckpt_req = 1'b1; settle("full_req");
        chk("full", 32'(bus.ckpt_full), 32'd1); advance();
        idle(); bus.ckpt_free = 1'b1; bus.ckpt_free_id = CW'(2); bus.ckpt_req = 1'b1; settle("free2"); advance();
        idle(); settle("after_free");
        chk("after free full", 32'(bus.ckpt_full), 32'd0);
        chk("after free id", 32'(bus.ckpt_id), 32'd2); advance();
`endif

        for (int n = 0; n < 800; n++) begin
            idle();
            reset = ($urandom_range(0, 63) != 0);
            for (int i = 0; i < DW; i++) begin
                bus.disp_valid[i] = ($urandom_range(0, 3) != 0);
                bus.disp_rs1[i] = 5'($urandom_range(0, 9));
                bus.disp_rs2[i] = 5'($urandom_range(0, 9));
                bus.disp_rd[i] = 5'($urandom_range(0, 9));
                bus.disp_tag[i] = TW'($urandom);
            end
            if ($urandom_range(0, 1) != 0) begin
                r = $urandom_range(1, 9);
                bus.cdb_valid = 1'b1; bus.cdb_rd = 5'(r);
                bus.cdb_tag = ($urandom_range(0, 3) != 0) ? m_map[r][TW:1] : TW'($urandom);
            end
            if ($urandom_range(0, 2) == 0) begin
                r = $urandom_range(1, 9);
                bus.commit_valid = 1'b1; bus.commit_rd = 5'(r);
                bus.commit_tag = ($urandom_range(0, 3) != 0) ? m_map[r][TW:1] : TW'($urandom);
            end
            bus.ckpt_req = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 19) == 0) begin
                bus.recover = 1'b1;
                if (!CKPT_EN) bus.recover_id = CW'($urandom);
                else if (order.size() > 0) bus.recover_id = CW'(order[$urandom_range(0, order.size() - 1)]);
                else bus.recover = 1'b0;
            end else if ($urandom_range(0, 7) == 0) begin
                bus.ckpt_free = 1'b1; bus.ckpt_free_id = CW'($urandom);
            end
            settle("rand");
            advance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
